mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage_load_extract.sv | 42 ++++
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, state encoding and bus payload layouts.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 80;
    localparam int unsigned MS_TO_WS_BUS_WD = 70;
    localparam int unsigned MS_FORWARD_WD   = 72;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } ms_state_e;

    // EXE -> MEM payload, first member is the MSB (bit 79)
    typedef struct packed {
        logic        mem_we;
        logic        ld_w;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        st_w;
        logic        st_b;
        logic        st_h;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    // MEM -> WB payload
    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    // Forwarding / hazard information for the decode stage
    typedef struct packed {
        logic        data_pending;
        logic [31:0] pc;
        logic [31:0] final_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        ms_valid;
    } ms_forward_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake, payload buses and data-SRAM response seen by the MEM stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FORWARD_WD-1:0]   ms_forward;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;

    // Environment side (EXE, WB, memory)
    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward
    );

    // MEM stage side
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward
    );

endinterface

// File: rtl/mem_stage_load_extract.sv
// Combinational load-data alignment: selects byte/halfword/word and extends to 32 bits.
module mem_stage_load_extract (
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic        ld_w_i,
    input  logic        ld_b_i,
    input  logic        ld_bu_i,
    input  logic        ld_h_i,
    input  logic        ld_hu_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend per load type
    always_comb begin
        byte_sel = word_i[7:0];
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // halfword loads ignore offset bit 0
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        result_o = word_i;
        if (ld_w_i) begin
            result_o = word_i;
        end else if (ld_b_i) begin
            result_o = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_bu_i) begin
            result_o = {24'd0, byte_sel};
        end else if (ld_h_i) begin
            result_o = {{16{half_sel[15]}}, half_sel};
        end else if (ld_hu_i) begin
            result_o = {16'd0, half_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for the data-SRAM response of
// memory ops, aligns load data and hands the result to WB with valid/allowin flow control.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave ms_if
);

    ms_state_e     state_q, state_d;
    es_to_ms_bus_t es_bus;
    es_to_ms_bus_t bus_q;
    logic [31:0]   rdata_q;

    logic          data_ok;
    logic          ms_valid;
    logic          wait_ok;
    logic          ready_go;
    logic          allowin;
    logic          in_fire;
    logic          in_mem_op;
    ms_state_e     enter_state;

    logic [31:0]   load_word;
    logic [31:0]   load_result;
    logic [31:0]   final_result;
    ms_to_ws_bus_t out_bus;
    ms_forward_t   fwd;
    logic          unused_store_flags;

    assign es_bus      = es_to_ms_bus_t'(ms_if.es_to_ms_bus);
    assign data_ok     = ms_if.data_sram_data_ok;
    assign in_mem_op   = es_bus.res_from_mem || es_bus.mem_we;
    assign enter_state = in_mem_op ? S_WAIT : S_READY;

    // Handshake decode and next-state selection
    always_comb begin
        state_d  = state_q;
        ms_valid = (state_q != S_EMPTY);
        wait_ok  = (state_q == S_WAIT) && data_ok;
        ready_go = (state_q == S_READY) || wait_ok;
        allowin  = !ms_valid || (ready_go && ms_if.ws_allowin);
        in_fire  = ms_if.es_to_ms_valid && allowin;

        case (state_q)
            S_EMPTY: begin
                if (in_fire) state_d = enter_state;
            end
            S_WAIT: begin
                // data_ok may retire the instruction in the same cycle it arrives
                if (in_fire)                          state_d = enter_state;
                else if (wait_ok && ms_if.ws_allowin) state_d = S_EMPTY;
                else if (wait_ok)                     state_d = S_READY;
            end
            S_READY: begin
                // stray data_ok here is a protocol error and is ignored
                if (in_fire)                state_d = enter_state;
                else if (ms_if.ws_allowin)  state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State register; reset drops any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    // Payload and response-hold registers; contents are don't-care while EMPTY
    always_ff @(posedge clk) begin
        if (in_fire) bus_q   <= es_bus;
        if (wait_ok) rdata_q <= ms_if.data_sram_rdata;
    end

    // Live response on the data_ok cycle, held copy afterwards
    assign load_word = wait_ok ? ms_if.data_sram_rdata : rdata_q;

    mem_stage_load_extract u_load_extract (
        .word_i   (load_word),
        .offset_i (bus_q.alu_result[1:0]),
        .ld_w_i   (bus_q.ld_w),
        .ld_b_i   (bus_q.ld_b),
        .ld_bu_i  (bus_q.ld_bu),
        .ld_h_i   (bus_q.ld_h),
        .ld_hu_i  (bus_q.ld_hu),
        .result_o (load_result)
    );

    assign final_result = bus_q.res_from_mem ? load_result : bus_q.alu_result;

    // Result and forwarding payload assembly
    always_comb begin
        out_bus              = '0;
        out_bus.gr_we        = bus_q.gr_we;
        out_bus.dest         = bus_q.dest;
        out_bus.final_result = final_result;
        out_bus.pc           = bus_q.pc;

        fwd              = '0;
        fwd.ms_valid     = ms_valid;
        fwd.gr_we        = bus_q.gr_we;
        fwd.dest         = bus_q.dest;
        fwd.final_result = final_result;
        fwd.pc           = bus_q.pc;
        fwd.data_pending = ms_valid && (state_q == S_WAIT) && bus_q.res_from_mem && !data_ok;
    end

    assign ms_if.ms_allowin     = allowin;
    assign ms_if.ms_to_ws_valid = ms_valid && ready_go;
    assign ms_if.ms_to_ws_bus   = MS_TO_WS_BUS_WD'(out_bus);
    assign ms_if.ms_forward     = MS_FORWARD_WD'(fwd);

    // Store width and mem_we only matter to the request issued in EXE
    assign unused_store_flags = ^{bus_q.mem_we, bus_q.st_w, bus_q.st_b, bus_q.st_h};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single instructions plus
// hand-written sequences for stalls, back-to-back flow and reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_stage_if bus_if();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .ms_if (bus_if.slave)
    );

    ms_to_ws_bus_t ob;
    ms_forward_t   fw;
    assign ob = ms_to_ws_bus_t'(bus_if.ms_to_ws_bus);
    assign fw = ms_forward_t'(bus_if.ms_forward);

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] LD_NONE = 5'b00000;
    localparam logic [4:0] LD_W    = 5'b10000;
    localparam logic [4:0] LD_B    = 5'b01000;
    localparam logic [4:0] LD_BU   = 5'b00100;
    localparam logic [4:0] LD_H    = 5'b00010;
    localparam logic [4:0] LD_HU   = 5'b00001;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic        rfm;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  ld;
        logic [2:0]  st;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_hs(input string tag, input logic ev, input logic ea, input logic ep);
        chk({tag, ".valid"},   32'(bus_if.ms_to_ws_valid), 32'(ev));
        chk({tag, ".allowin"}, 32'(bus_if.ms_allowin),     32'(ea));
        chk({tag, ".pending"}, 32'(fw.data_pending),       32'(ep));
    endtask

    function automatic es_to_ms_bus_t mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                             input logic [4:0] dest, input logic gr_we,
                                             input logic rfm, input logic mem_we,
                                             input logic [4:0] ld, input logic [2:0] st);
        es_to_ms_bus_t b;
        b = '0;
        b.pc           = pc;
        b.alu_result   = alu;
        b.dest         = dest;
        b.gr_we        = gr_we;
        b.res_from_mem = rfm;
        b.mem_we       = mem_we;
        {b.ld_w, b.ld_b, b.ld_bu, b.ld_h, b.ld_hu} = ld;
        {b.st_w, b.st_b, b.st_h} = st;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.es_to_ms_bus      = '0;
        bus_if.ws_allowin        = 1'b1;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = '0;
    endtask

    task automatic enter(input es_to_ms_bus_t b);
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = ES_TO_MS_BUS_WD'(b);
    endtask

    initial begin
        vecs[0] = '{32'h1c00_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, LD_NONE, 3'b000, 32'h0,         32'h1234_5678};
        vecs[1] = '{32'h1c00_0004, 32'h1c00_0100, 1'b1, 1'b0, 1'b1, LD_W,    3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{32'h1c00_0008, 32'h1c00_0100, 1'b1, 1'b0, 1'b1, LD_B,    3'b000, 32'h1122_3380, 32'hFFFF_FF80};
        vecs[3] = '{32'h1c00_000c, 32'h1c00_0101, 1'b1, 1'b0, 1'b1, LD_BU,   3'b000, 32'h1122_F344, 32'h0000_00F3};
        vecs[4] = '{32'h1c00_0010, 32'h1c00_0102, 1'b1, 1'b0, 1'b1, LD_B,    3'b000, 32'h1172_3344, 32'h0000_0072};
        vecs[5] = '{32'h1c00_0014, 32'h1c00_0100, 1'b1, 1'b0, 1'b1, LD_H,    3'b000, 32'h1234_8001, 32'hFFFF_8001};
        vecs[6] = '{32'h1c00_0018, 32'h1c00_0102, 1'b1, 1'b0, 1'b1, LD_H,    3'b000, 32'h7FFF_0000, 32'h0000_7FFF};
        vecs[7] = '{32'h1c00_001c, 32'h1c00_0103, 1'b1, 1'b0, 1'b1, LD_HU,   3'b000, 32'hABCD_1234, 32'h0000_ABCD};
        vecs[8] = '{32'h1c00_0020, 32'h1c00_0103, 1'b1, 1'b0, 1'b1, LD_BU,   3'b000, 32'hFF00_0000, 32'h0000_00FF};
        vecs[9] = '{32'h1c00_0024, 32'h0000_0007, 1'b0, 1'b1, 1'b0, LD_NONE, 3'b010, 32'h5555_5555, 32'h0000_0007};

        // Reset state
        idle();
        reset = 1'b1;
        #12;
        chk_hs("reset", 1'b0, 1'b1, 1'b0);
        chk("reset.fwd_valid", 32'(fw.ms_valid), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Table: one instruction each, WB always ready
        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            enter(mk_bus(vecs[i].pc, vecs[i].alu, 5'(i + 1), vecs[i].gr_we,
                         vecs[i].rfm, vecs[i].mem_we, vecs[i].ld, vecs[i].st));
            settle();
            chk({t, ".entry_allowin"}, 32'(bus_if.ms_allowin), 32'd1);
            step();
            idle();
            if (vecs[i].rfm || vecs[i].mem_we) begin
                settle();
                chk_hs({t, ".wait"}, 1'b0, 1'b0, vecs[i].rfm);
                step();
                bus_if.data_sram_data_ok = 1'b1;
                bus_if.data_sram_rdata   = vecs[i].rdata;
            end
            settle();
            chk_hs({t, ".out"}, 1'b1, 1'b1, 1'b0);
            chk({t, ".result"}, ob.final_result, vecs[i].exp);
            chk({t, ".pc"},     ob.pc,           vecs[i].pc);
            chk({t, ".dest"},   32'(ob.dest),    32'(5'(i + 1)));
            chk({t, ".gr_we"},  32'(ob.gr_we),   32'(vecs[i].gr_we));
            chk({t, ".fwd_res"}, fw.final_result, vecs[i].exp);
            chk({t, ".fwd_valid"}, 32'(fw.ms_valid), 32'd1);
            step();
            idle();
            settle();
            chk_hs({t, ".empty"}, 1'b0, 1'b1, 1'b0);
            step();
        end

        // ld_b offset 3, response after two waiting cycles
        enter(mk_bus(32'h1c00_0100, 32'h1c00_0203, 5'd4, 1'b1, 1'b1, 1'b0, LD_B, 3'b000));
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            settle();
            chk_hs($sformatf("ldb_wait%0d", k), 1'b0, 1'b0, 1'b1);
            step();
        end
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h8011_2233;
        settle();
        chk_hs("ldb_ok", 1'b1, 1'b1, 1'b0);
        chk("ldb_ok.result", ob.final_result, 32'hFFFF_FF80);
        step();
        idle();
        settle();
        chk_hs("ldb_empty", 1'b0, 1'b1, 1'b0);
        step();

        // ld_hu offset 2 with WB stalled: result held, stray data_ok ignored
        enter(mk_bus(32'h1c00_0200, 32'h1c00_0302, 5'd5, 1'b1, 1'b1, 1'b0, LD_HU, 3'b000));
        step();
        idle();
        bus_if.ws_allowin        = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h9ABC_0000;
        settle();
        chk_hs("ldhu_ok", 1'b1, 1'b0, 1'b0);
        chk("ldhu_ok.result", ob.final_result, 32'h0000_9ABC);
        step();
        for (int k = 0; k < 3; k++) begin
            bus_if.data_sram_data_ok = (k == 1);
            bus_if.data_sram_rdata   = (k == 1) ? 32'h1111_2222 : 32'hFFFF_FFFF;
            settle();
            chk_hs($sformatf("ldhu_hold%0d", k), 1'b1, 1'b0, 1'b0);
            chk($sformatf("ldhu_hold%0d.result", k), ob.final_result, 32'h0000_9ABC);
            step();
        end
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.ws_allowin        = 1'b1;
        settle();
        chk_hs("ldhu_release", 1'b1, 1'b1, 1'b0);
        chk("ldhu_release.result", ob.final_result, 32'h0000_9ABC);
        step();
        idle();
        settle();
        chk_hs("ldhu_empty", 1'b0, 1'b1, 1'b0);
        step();

        // Back-to-back: load leaves on data_ok while the next ALU op enters
        enter(mk_bus(32'h1c00_0300, 32'h1c00_0400, 5'd6, 1'b1, 1'b1, 1'b0, LD_W, 3'b000));
        step();
        enter(mk_bus(32'h1c00_0304, 32'h0000_0042, 5'd7, 1'b1, 1'b0, 1'b0, LD_NONE, 3'b000));
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hCAFE_F00D;
        settle();
        chk_hs("b2b_first", 1'b1, 1'b1, 1'b0);
        chk("b2b_first.result", ob.final_result, 32'hCAFE_F00D);
        chk("b2b_first.pc",     ob.pc,           32'h1c00_0300);
        step();
        idle();
        settle();
        chk_hs("b2b_second", 1'b1, 1'b1, 1'b0);
        chk("b2b_second.result", ob.final_result, 32'h0000_0042);
        chk("b2b_second.pc",     ob.pc,           32'h1c00_0304);
        step();
        settle();
        chk_hs("b2b_empty", 1'b0, 1'b1, 1'b0);
        step();

        // Reset mid-WAIT, then a stray data_ok
        enter(mk_bus(32'h1c00_0400, 32'h1c00_0500, 5'd8, 1'b1, 1'b1, 1'b0, LD_W, 3'b000));
        step();
        idle();
        settle();
        chk_hs("rst_wait", 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk_hs("rst_async", 1'b0, 1'b1, 1'b0);
        chk("rst_async.fwd_valid", 32'(fw.ms_valid), 32'd0);
        step();
        reset = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h1212_1212;
        settle();
        chk_hs("rst_stray", 1'b0, 1'b1, 1'b0);
        chk("rst_stray.fwd_valid", 32'(fw.ms_valid), 32'd0);
        step();
        idle();
        settle();
        chk_hs("rst_after", 1'b0, 1'b1, 1'b0);
        chk("rst_after.fwd_valid", 32'(fw.ms_valid), 32'd0);
        step();

        // st_w: one waiting cycle, never pending, result is the address
        enter(mk_bus(32'h1c00_0500, 32'h1c00_0600, 5'd0, 1'b0, 1'b0, 1'b1, LD_NONE, 3'b100));
        step();
        idle();
        settle();
        chk_hs("stw_wait", 1'b0, 1'b0, 1'b0);
        step();
        bus_if.data_sram_data_ok = 1'b1;
        settle();
        chk_hs("stw_ok", 1'b1, 1'b1, 1'b0);
        chk("stw_ok.result", ob.final_result, 32'h1c00_0600);
        chk("stw_ok.gr_we",  32'(ob.gr_we),   32'd0);
        step();
        idle();
        settle();
        chk_hs("stw_empty", 1'b0, 1'b1, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
